// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage feeding the IF/ID register
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   stall[5:0]               pipeline stall vector; only stall[0] (hold PC) is used here
//   flush, new_pc            exception redirect; highest priority
//   branch_flag_i,
//   branch_target_address_i  taken branch resolved in ID
//   inst_sram_*              synchronous instruction SRAM port (read-only use)
//   pc_o, inst_o, adel_o     PC / instruction / address-error pair for IF/ID

module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic              inst_sram_en,
    output logic [3:0]        inst_sram_wen,
    output logic [ADDR_W-1:0] inst_sram_addr,
    output logic [31:0]       inst_sram_wdata,
    input  logic [31:0]       inst_sram_rdata,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              adel_o
);

    logic [ADDR_W-1:0] pc;
    logic              fetch_valid;
    logic              buf_valid;
    logic [31:0]       buf_inst;
    logic              adel;

    logic [ADDR_W-1:0] next_pc;
    logic              advance;
    logic              valid;

    // Only stall[0] concerns the fetch stage; the upper bits belong to later stages.
    logic stall_unused;
    assign stall_unused = ^stall[5:1];

    // A flush overrides a stall, so the PC moves whenever either is true.
    assign advance = flush | ~stall[0];

    always_comb begin
        next_pc = pc;
        if (flush) begin
            next_pc = new_pc;
        end else if (stall[0]) begin
            next_pc = pc;
        end else if (branch_flag_i) begin
            next_pc = branch_target_address_i;
        end else begin
            next_pc = pc + ADDR_W'(4);
        end
    end

    // Misaligned targets never reach the SRAM; the error travels with pc_o instead.
    assign inst_sram_en    = advance & (next_pc[1:0] == 2'b00) & rst;
    assign inst_sram_addr  = inst_sram_en ? next_pc : pc;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC - ADDR_W'(4);
            fetch_valid <= 1'b0;
            buf_valid   <= 1'b0;
            buf_inst    <= 32'h0;
            adel        <= 1'b0;
        end else if (advance) begin
            pc          <= next_pc;
            fetch_valid <= 1'b1;
            adel        <= (next_pc[1:0] != 2'b00);
            buf_valid   <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            // The SRAM word is only on rdata for the first stalled cycle; catch it once.
            if (fetch_valid && !buf_valid) begin
                buf_inst  <= inst_sram_rdata;
                buf_valid <= 1'b1;
            end
        end
    end

    assign valid  = fetch_valid | buf_valid;
    assign pc_o   = valid ? pc : '0;
    assign inst_o = adel        ? 32'h0 :
                    buf_valid   ? buf_inst :
                    fetch_valid ? inst_sram_rdata : 32'h0;
    assign adel_o = valid & adel;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage

module tb_if_fetch_stage;

    localparam logic [31:0] B = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_address_i = '0;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        adel_o;

    int n_chk  = 0;
    int n_fail = 0;

    if_fetch_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .inst_sram_en            (inst_sram_en),
        .inst_sram_wen           (inst_sram_wen),
        .inst_sram_addr          (inst_sram_addr),
        .inst_sram_wdata         (inst_sram_wdata),
        .inst_sram_rdata         (inst_sram_rdata),
        .pc_o                    (pc_o),
        .inst_o                  (inst_o),
        .adel_o                  (adel_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C30F96;
    endfunction

    // SRAM: word appears the cycle after an enabled read; otherwise rdata is junk.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= pat(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] npc;
        logic        br;
        logic [31:0] tgt;
        logic        en;
        logic [31:0] addr;
        logic [31:0] pco;
        logic [31:0] inst;
        logic        adel;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] s, input logic f, input logic [31:0] np,
                                input logic b, input logic [31:0] t, input logic e,
                                input logic [31:0] a, input logic [31:0] p,
                                input logic [31:0] i, input logic ad);
        vec_t v;
        v.stall = s; v.flush = f; v.npc = np; v.br = b; v.tgt = t;
        v.en = e; v.addr = a; v.pco = p; v.inst = i; v.adel = ad;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        stall = '0; flush = 1'b0; branch_flag_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    vec_t tbl[17];

    // Reference model: the presented instruction is always the memory word at pc_o.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_adel;

    initial begin
        logic        adv;
        logic [31:0] npc;
        logic        e_en;

        tbl[0]  = mk(6'h00, 0, 0, 0, 0,          1, B,          0,          0,                0);
        tbl[1]  = mk(6'h00, 0, 0, 0, 0,          1, B+4,        B,          pat(B),           0);
        tbl[2]  = mk(6'h00, 0, 0, 0, 0,          1, B+8,        B+4,        pat(B+4),         0);
        tbl[3]  = mk(6'h01, 0, 0, 0, 0,          0, B+8,        B+8,        pat(B+8),         0);
        tbl[4]  = mk(6'h3F, 0, 0, 0, 0,          0, B+8,        B+8,        pat(B+8),         0);
        tbl[5]  = mk(6'h01, 0, 0, 0, 0,          0, B+8,        B+8,        pat(B+8),         0);
        tbl[6]  = mk(6'h00, 0, 0, 0, 0,          1, B+'hC,      B+8,        pat(B+8),         0);
        tbl[7]  = mk(6'h00, 0, 0, 1, B+'h100,    1, B+'h100,    B+'hC,      pat(B+'hC),       0);
        tbl[8]  = mk(6'h01, 0, 0, 1, B+'h200,    0, B+'h100,    B+'h100,    pat(B+'h100),     0);
        tbl[9]  = mk(6'h01, 1, B+'h380, 1, B+'h200, 1, B+'h380, B+'h100,    pat(B+'h100),     0);
        tbl[10] = mk(6'h00, 0, 0, 1, B+'h102,    0, B+'h380,    B+'h380,    pat(B+'h380),     0);
        tbl[11] = mk(6'h00, 1, B+'h380, 0, 0,    1, B+'h380,    B+'h102,    0,                1);
        tbl[12] = mk(6'h00, 0, 0, 0, 0,          1, B+'h384,    B+'h380,    pat(B+'h380),     0);
        tbl[13] = mk(6'h00, 1, 32'hFFFFFFFC, 0, 0, 1, 32'hFFFFFFFC, B+'h384, pat(B+'h384),     0);
        tbl[14] = mk(6'h00, 0, 0, 0, 0,          1, 0,          32'hFFFFFFFC, pat(32'hFFFFFFFC), 0);
        tbl[15] = mk(6'h01, 0, 0, 0, 0,          0, 0,          0,          pat(0),           0);
        tbl[16] = mk(6'h01, 0, 0, 0, 0,          0, 0,          0,          pat(0),           0);

        // Reset state
        #2;
        chk("reset en",    32'(inst_sram_en), 0);
        chk("reset wen",   32'(inst_sram_wen), 0);
        chk("reset wdata", inst_sram_wdata, 0);
        chk("reset pc_o",  pc_o, 0);
        chk("reset inst",  inst_o, 0);
        chk("reset adel",  32'(adel_o), 0);
        do_reset();

        // Directed table
        for (int i = 0; i < 17; i++) begin
            stall = tbl[i].stall; flush = tbl[i].flush; new_pc = tbl[i].npc;
            branch_flag_i = tbl[i].br; branch_target_address_i = tbl[i].tgt;
            @(negedge clk);
            chk($sformatf("v%0d en", i),   32'(inst_sram_en), 32'(tbl[i].en));
            chk($sformatf("v%0d addr", i), inst_sram_addr, tbl[i].addr);
            chk($sformatf("v%0d pc_o", i), pc_o, tbl[i].pco);
            chk($sformatf("v%0d inst", i), inst_o, tbl[i].inst);
            chk($sformatf("v%0d adel", i), 32'(adel_o), 32'(tbl[i].adel));
            @(posedge clk); #1;
        end

        // Asynchronous reset during a stall with the buffer full
        flush = 1'b0; branch_flag_i = 1'b0; stall = 6'h01;
        #2 rst = 1'b0;
        #1;
        chk("async rst pc_o", pc_o, 0);
        chk("async rst inst", inst_o, 0);
        chk("async rst adel", 32'(adel_o), 0);
        chk("async rst en",   32'(inst_sram_en), 0);
        @(posedge clk); #1;
        stall = '0; rst = 1'b1;
        @(negedge clk);
        chk("post rst en",   32'(inst_sram_en), 1);
        chk("post rst addr", inst_sram_addr, B);
        chk("post rst pc_o", pc_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post rst pc1",   pc_o, B);
        chk("post rst inst1", inst_o, pat(B));
        chk("post rst addr1", inst_sram_addr, B+4);
        @(posedge clk); #1;

        // Randomized run against the reference model
        do_reset();
        m_pc = B - 4; m_valid = 1'b0; m_adel = 1'b0;
        for (int c = 0; c < 600; c++) begin
            stall = 6'($urandom);
            stall[0] = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 9) == 0);
            branch_flag_i = ($urandom_range(0, 9) < 2);
            branch_target_address_i = B + ($urandom_range(0, 255) << 2)
                                      + (($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
            case ($urandom_range(0, 7))
                0:       new_pc = 32'hFFFFFFF8;
                1:       new_pc = 32'hFFFFFFFC;
                2:       new_pc = B + 'h381;
                default: new_pc = B + 'h380;
            endcase

            adv = flush || !stall[0];
            if (flush)              npc = new_pc;
            else if (stall[0])      npc = m_pc;
            else if (branch_flag_i) npc = branch_target_address_i;
            else                    npc = m_pc + 4;
            e_en = adv && (npc % 4 == 0);

            @(negedge clk);
            chk($sformatf("r%0d en", c),   32'(inst_sram_en), 32'(e_en));
            chk($sformatf("r%0d addr", c), inst_sram_addr, e_en ? npc : m_pc);
            chk($sformatf("r%0d pc_o", c), pc_o, m_valid ? m_pc : 0);
            chk($sformatf("r%0d inst", c), inst_o, (m_valid && !m_adel) ? pat(m_pc) : 0);
            chk($sformatf("r%0d adel", c), 32'(adel_o), 32'(m_valid && m_adel));
            @(posedge clk); #1;

            if (adv) begin
                m_pc    = npc;
                m_valid = 1'b1;
                m_adel  = (npc % 4 != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
